// File: rtl/nf_ctrl.sv
// nf_ctrl: sequencer for a parallel NOR flash bus. Turns single-cycle
// READ / PROGRAM requests into SETUP/PULSE/HOLD bus cycles, drives NF_D
// during writes and polls NF_STS for program completion.
module nf_ctrl #(
    parameter int AW          = 8,
    parameter int T_SETUP     = 2,
    parameter int T_PULSE     = 4,
    parameter int T_HOLD      = 2,
    parameter int STS_TIMEOUT = 1000,
    parameter int BYTE_MODE   = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ,
    input  logic          OP,
    input  logic [AW-1:0] ADDR,
    input  logic [7:0]    WDATA,
    output logic          BUSY,
    output logic          DONE,
    output logic [7:0]    RDATA,
    output logic          ERR,
    output logic [AW-1:0] NF_A,
    inout  wire  [7:0]    NF_D,
    output logic          NF_CE,
    output logic          NF_OE,
    output logic          NF_WE,
    output logic          NF_RP,
    output logic          NF_WP,
    output logic          NF_BYTE,
    input  logic          NF_STS
);
    localparam int TM1  = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int TMAX = (TM1 > T_HOLD) ? TM1 : T_HOLD;
    localparam int CW   = $clog2(TMAX + 1);
    localparam int SW   = $clog2(STS_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_STS, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;      // cycles left in the current phase, minus one
    logic [SW-1:0] stc_q, stc_d;      // cycles already spent in STS_WAIT
    logic [1:0]    wcyc_q, wcyc_d;    // program write index: 0x40, data, 0xFF
    logic          op_q, op_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          rp_q;
    logic          sts_s1_q, sts_s2_q;
    logic          ce, oe, we, drv;
    logic [7:0]    dout;

    // State and datapath registers; reset aborts any cycle in flight.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            stc_q    <= '0;
            wcyc_q   <= '0;
            op_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            rp_q     <= 1'b0;
            sts_s1_q <= 1'b0;
            sts_s2_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stc_q    <= stc_d;
            wcyc_q   <= wcyc_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            rp_q     <= 1'b1;
            sts_s1_q <= NF_STS;
            sts_s2_q <= sts_s1_q;
        end
    end

    // Next-state logic: phase countdown, program command chain, status poll.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stc_d   = stc_q;
        wcyc_d  = wcyc_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (REQ) begin
                op_d    = OP;
                addr_d  = ADDR;
                wdata_d = WDATA;
                err_d   = 1'b0;
                wcyc_d  = 2'd0;
                cnt_d   = CW'(T_SETUP - 1);
                state_d = S_SETUP;
            end
            S_SETUP: if (cnt_q == '0) begin
                cnt_d   = CW'(T_PULSE - 1);
                state_d = S_PULSE;
            end else cnt_d = cnt_q - 1'b1;
            S_PULSE: if (cnt_q == '0) begin
                if (!op_q) rdata_d = NF_D;
                cnt_d   = CW'(T_HOLD - 1);
                state_d = S_HOLD;
            end else cnt_d = cnt_q - 1'b1;
            S_HOLD: if (cnt_q == '0) begin
                if (!op_q || wcyc_q == 2'd2) begin
                    state_d = S_DONE;
                end else if (wcyc_q == 2'd0) begin
                    wcyc_d  = 2'd1;
                    cnt_d   = CW'(T_SETUP - 1);
                    state_d = S_SETUP;
                end else begin
                    stc_d   = '0;
                    state_d = S_STS;
                end
            end else cnt_d = cnt_q - 1'b1;
            S_STS: begin
                // Ready wins over timeout when both hit on the same cycle.
                if (int'(stc_q) >= 2 && sts_s2_q) begin
                    wcyc_d  = 2'd2;
                    cnt_d   = CW'(T_SETUP - 1);
                    state_d = S_SETUP;
                end else if (int'(stc_q) >= STS_TIMEOUT - 1) begin
                    err_d   = 1'b1;
                    wcyc_d  = 2'd2;
                    cnt_d   = CW'(T_SETUP - 1);
                    state_d = S_SETUP;
                end else stc_d = stc_q + 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus strobe decode; writes own NF_D from SETUP through HOLD.
    always_comb begin
        ce  = 1'b1;
        oe  = 1'b1;
        we  = 1'b1;
        drv = 1'b0;
        case (state_q)
            S_SETUP: begin ce = 1'b0; drv = op_q; end
            S_PULSE: begin ce = 1'b0; oe = op_q; we = !op_q; drv = op_q; end
            S_HOLD:  drv = op_q;
            default: ;
        endcase
    end

    assign dout    = (wcyc_q == 2'd0) ? 8'h40 : (wcyc_q == 2'd1) ? wdata_q : 8'hFF;
    assign NF_D    = drv ? dout : 8'hzz;
    assign NF_A    = addr_q;
    assign NF_CE   = ce;
    assign NF_OE   = oe;
    assign NF_WE   = we;
    assign NF_RP   = rp_q;
    assign NF_WP   = 1'b1;
    assign NF_BYTE = (BYTE_MODE != 0);
    assign BUSY    = (state_q != S_IDLE);
    assign DONE    = (state_q == S_DONE);
    assign RDATA   = rdata_q;
    assign ERR     = err_q;
endmodule

// File: tb/tb_nf_ctrl.sv
// Bench for nf_ctrl: a flash device model plus a per-cycle expected-bus
// schedule built from the sequencing rules, compared every cycle.
module tb_nf_ctrl;
    localparam int TS = 2, TP = 4, TH = 2, TO = 20, P = TS + TP + TH;

    logic       CLK = 1'b0, RST = 1'b0, REQ = 1'b0, OP = 1'b0;
    logic [7:0] ADDR = '0, WDATA = '0;
    logic       BUSY, DONE, ERR, NF_CE, NF_OE, NF_WE, NF_RP, NF_WP, NF_BYTE;
    logic [7:0] RDATA, NF_A;
    logic       NF_STS = 1'b1;
    wire  [7:0] NF_D;

    nf_ctrl #(.AW(8), .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH),
              .STS_TIMEOUT(TO), .BYTE_MODE(1)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .OP(OP), .ADDR(ADDR), .WDATA(WDATA),
        .BUSY(BUSY), .DONE(DONE), .RDATA(RDATA), .ERR(ERR), .NF_A(NF_A),
        .NF_D(NF_D), .NF_CE(NF_CE), .NF_OE(NF_OE), .NF_WE(NF_WE),
        .NF_RP(NF_RP), .NF_WP(NF_WP), .NF_BYTE(NF_BYTE), .NF_STS(NF_STS));

    always #5 CLK = ~CLK;

    // Undriven bus floats high so a released NF_D reads 0xFF.
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (NF_D[i]);
    end

    // ---------------- flash device model ----------------
    logic [7:0] mem [256];
    logic [7:0] wlog [$];
    logic       fl_en;
    logic       init_done = 1'b0, wl_act = 1'b0, pend = 1'b0;
    logic [7:0] d_lat = '0, a_lat = '0;

    assign fl_en = !NF_CE && !NF_OE && NF_WE;
    assign NF_D  = fl_en ? mem[NF_A] : 8'hzz;

    always @(negedge CLK) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h59;  // mem[0x0C] = 0x55
            init_done = 1'b1;
        end
        if (wl_act && NF_WE) begin
            wlog.push_back(d_lat);
            if (pend) begin mem[a_lat] = d_lat; pend = 1'b0; end
            else pend = (d_lat == 8'h40);
        end
        wl_act = !NF_WE && !NF_CE;
        if (wl_act) begin d_lat = NF_D; a_lat = NF_A; end
    end

    // ---------------- expected-behaviour model ----------------
    typedef struct packed {
        logic idle, busy, done, ce, oe, we, drv, err, rp;
        logic [7:0] d, a, rd;
        logic [15:0] k;
    } ent_t;

    ent_t q [$];
    ent_t cur;
    int   lo_s = 0, lo_e = 0;   // NF_STS held low on cycles [lo_s, lo_e) after accept

    function automatic logic sts_raw(input int c);
        return !(c >= lo_s && c < lo_e);
    endfunction

    task automatic bus_cyc(input logic wr, input logic [7:0] d, input logic [7:0] rdnew,
                           inout ent_t e);
        e.idle = 0; e.busy = 1; e.done = 0; e.drv = wr; e.d = wr ? d : 8'h00;
        for (int i = 0; i < TS; i++) begin
            e.ce = 0; e.oe = 1; e.we = 1; e.k = e.k + 1; q.push_back(e);
        end
        for (int i = 0; i < TP; i++) begin
            e.ce = 0; e.oe = wr; e.we = !wr; e.k = e.k + 1; q.push_back(e);
        end
        if (!wr) e.rd = rdnew;
        for (int i = 0; i < TH; i++) begin
            e.ce = 1; e.oe = 1; e.we = 1; e.k = e.k + 1; q.push_back(e);
        end
    endtask

    task automatic build(input logic op, input logic [7:0] a, input logic [7:0] w);
        ent_t e;
        int   len;
        logic tmo;
        e = cur; e.a = a; e.err = 0; e.k = 0; e.rp = 1;
        if (!op) bus_cyc(1'b0, 8'h00, mem[a], e);
        else begin
            bus_cyc(1'b1, 8'h40, 8'h00, e);
            bus_cyc(1'b1, w, 8'h00, e);
            len = TO; tmo = 1'b1;
            // Status seen through two sync flops; first two wait cycles are blind.
            for (int j = 0; j < TO; j++) begin
                if (j >= 2 && sts_raw(2 * P + 1 + j - 2)) begin len = j + 1; tmo = 1'b0; break; end
            end
            e.busy = 1; e.ce = 1; e.oe = 1; e.we = 1; e.drv = 0;
            for (int j = 0; j < len; j++) begin e.k = e.k + 1; q.push_back(e); end
            e.err = tmo;
            bus_cyc(1'b1, 8'hFF, 8'h00, e);
        end
        e.done = 1; e.busy = 1; e.ce = 1; e.oe = 1; e.we = 1; e.drv = 0; e.k = e.k + 1;
        q.push_back(e);
    endtask

    always @(posedge CLK) begin
        if (!RST) begin
            q.delete();
            cur = '0; cur.idle = 1; cur.ce = 1; cur.oe = 1; cur.we = 1;
        end else begin
            if (cur.idle && REQ) build(OP, ADDR, WDATA);
            if (q.size() > 0) cur = q.pop_front();
            else begin
                cur.idle = 1; cur.busy = 0; cur.done = 0; cur.ce = 1; cur.oe = 1;
                cur.we = 1; cur.drv = 0; cur.k = 0;
            end
            cur.rp = 1;
        end
        NF_STS <= (cur.k == 0) ? 1'b1 : sts_raw(int'(cur.k));
    end

    // ---------------- checking and stimulus ----------------
    int checks = 0, failures = 0;
    int ce_lo = 0, oe_lo = 0, done_n = 0, last_done_k = 0, gcyc = 0;
    int done_cyc [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, act, exp, gcyc);
        end
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_n == d0 && n < 200) begin @(posedge CLK); n++; end
        chk("done_seen", 32'(done_n != d0), 32'd1);
        @(posedge CLK);
    endtask

    task automatic req(input logic op, input logic [7:0] a, input logic [7:0] w);
        int d0;
        d0 = done_n;
        @(posedge CLK); #1; REQ = 1; OP = op; ADDR = a; WDATA = w;
        @(posedge CLK); #1; REQ = 0;
        wait_done(d0);
    endtask

    initial begin
        int c0, o0, d0, w0, n;
        fork
            forever begin
                logic [7:0] exp_d;
                @(negedge CLK);
                gcyc++;
                exp_d = cur.drv ? cur.d : (!cur.ce && !cur.oe) ? mem[cur.a] : 8'hFF;
                chk("BUSY", 32'(BUSY), 32'(cur.busy));
                chk("DONE", 32'(DONE), 32'(cur.done));
                chk("NF_CE", 32'(NF_CE), 32'(cur.ce));
                chk("NF_OE", 32'(NF_OE), 32'(cur.oe));
                chk("NF_WE", 32'(NF_WE), 32'(cur.we));
                chk("NF_RP", 32'(NF_RP), 32'(cur.rp));
                chk("ERR", 32'(ERR), 32'(cur.err));
                chk("RDATA", 32'(RDATA), 32'(cur.rd));
                chk("NF_A", 32'(NF_A), 32'(cur.a));
                chk("NF_D", 32'(NF_D), 32'(exp_d));
                chk("NF_WP", 32'(NF_WP), 32'd1);
                chk("NF_BYTE", 32'(NF_BYTE), 32'd1);
                if (!NF_CE) ce_lo++;
                if (!NF_OE) oe_lo++;
                if (DONE) begin done_n++; last_done_k = int'(cur.k); done_cyc.push_back(gcyc); end
            end
        join_none

        // Reset held for three edges, then released.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_rp", 32'(NF_RP), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        @(posedge CLK); #1; RST = 1;
        @(posedge CLK); @(negedge CLK);
        chk("rp_after_release", 32'(NF_RP), 32'd1);

        // READ 0x0C.
        c0 = ce_lo; o0 = oe_lo; d0 = done_n;
        req(1'b0, 8'h0C, 8'h00);
        chk("rd_ce_low_cycles", 32'(ce_lo - c0), 32'd6);
        chk("rd_oe_low_cycles", 32'(oe_lo - o0), 32'd4);
        chk("rd_done_cycle", 32'(last_done_k), 32'd9);
        chk("rd_done_count", 32'(done_n - d0), 32'd1);
        chk("rd_data", 32'(RDATA), 32'h55);

        // PROGRAM 0x0C <- 0x55 with STS low for 10 cycles.
        lo_s = 15; lo_e = 25; w0 = wlog.size(); d0 = done_n;
        req(1'b1, 8'h0C, 8'h55);
        chk("pg_we_pulses", 32'(wlog.size() - w0), 32'd3);
        if (wlog.size() >= w0 + 3) begin
            chk("pg_w0", 32'(wlog[w0]), 32'h40);
            chk("pg_w1", 32'(wlog[w0 + 1]), 32'h55);
            chk("pg_w2", 32'(wlog[w0 + 2]), 32'hFF);
        end
        chk("pg_err", 32'(ERR), 32'd0);
        chk("pg_done_cycle", 32'(last_done_k), 32'd36);
        chk("pg_done_count", 32'(done_n - d0), 32'd1);
        lo_s = 0; lo_e = 0;
        req(1'b0, 8'h0C, 8'h00);
        chk("pg_readback", 32'(RDATA), 32'h55);

        // PROGRAM with STS already ready: exits right after blanking.
        req(1'b1, 8'h21, 8'hA7);
        chk("pg2_done_cycle", 32'(last_done_k), 32'd28);
        req(1'b0, 8'h21, 8'h00);
        chk("pg2_readback", 32'(RDATA), 32'hA7);

        // STS stuck low: timeout, 0xFF still issued.
        lo_s = 1; lo_e = 100000; w0 = wlog.size();
        req(1'b1, 8'h30, 8'h3C);
        chk("to_err", 32'(ERR), 32'd1);
        chk("to_done_cycle", 32'(last_done_k), 32'd45);
        if (wlog.size() >= w0 + 3) chk("to_last_write", 32'(wlog[w0 + 2]), 32'hFF);
        else chk("to_we_pulses", 32'(wlog.size() - w0), 32'd3);
        lo_s = 0; lo_e = 0;
        @(posedge CLK); #1; REQ = 1; OP = 0; ADDR = 8'h30;
        @(posedge CLK); #1; REQ = 0;
        @(negedge CLK);
        chk("err_cleared_on_accept", 32'(ERR), 32'd0);
        wait_done(done_n);

        // REQ held high: accepts only out of IDLE, one idle cycle between.
        d0 = done_n;
        @(posedge CLK); #1; REQ = 1; OP = 0; ADDR = 8'h0C;
        repeat (25) @(posedge CLK);
        #1; REQ = 0;
        n = 0;
        while (BUSY && n < 100) begin @(posedge CLK); n++; end
        chk("held_idle_reached", 32'(n < 100), 32'd1);
        @(negedge CLK);
        chk("held_done_count", 32'(done_n - d0), 32'd3);
        if (done_cyc.size() >= 2)
            chk("held_done_spacing", 32'(done_cyc[$] - done_cyc[$ - 1]), 32'd10);

        // Reset during READ PULSE.
        d0 = done_n;
        @(posedge CLK); #1; REQ = 1; OP = 0; ADDR = 8'h21;
        @(posedge CLK); #1; REQ = 0;
        repeat (3) @(posedge CLK);
        #1; RST = 0;
        @(posedge CLK); @(negedge CLK);
        chk("abort_oe", 32'(NF_OE), 32'd1);
        chk("abort_ce", 32'(NF_CE), 32'd1);
        chk("abort_d", 32'(NF_D), 32'hFF);
        @(posedge CLK); #1; RST = 1;
        repeat (3) @(posedge CLK);
        chk("abort_no_done", 32'(done_n - d0), 32'd0);
        req(1'b0, 8'h21, 8'h00);
        chk("post_abort_read", 32'(RDATA), 32'hA7);

        repeat (3) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
